// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: ALU/instruction
// opcodes (op_mne), controller state encoding and LUT index width.
package ctrl_sequencer_pkg;

  localparam int LUT_IDXW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_CMP  = 4'h7,
    OP_MOV  = 4'h8,
    OP_BNZ  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_NOP  = 4'hC,
    OP_HALT = 4'hF
  } op_mne;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } ctrl_state_t;

  // 0xC..0xE are all treated as no-ops
  function automatic logic is_nop(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_branch_lut.sv
// Branch target table: 5-bit index from the BNZ operand to an absolute
// program-counter target. Purely combinational.
module ctrl_sequencer_branch_lut
  import ctrl_sequencer_pkg::*;
#(
  parameter int PCW = 10
) (
  input  logic [LUT_IDXW-1:0] idx,
  output logic [PCW-1:0]      target
);

  always_comb begin
    target = '0;
    case (idx)
      5'd0:    target = PCW'(0);
      5'd1:    target = PCW'(16);
      5'd2:    target = PCW'(32);
      5'd3:    target = PCW'(40);
      5'd4:    target = PCW'(100);
      5'd5:    target = PCW'(5);
      5'd31:   target = PCW'(1023);
      // remaining slots spread targets on 16-word boundaries
      default: target = PCW'({idx, 4'b0000});
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM: fetches instructions from a combinational ROM,
// drives the ALU opcode, sequences reg-file/memory strobes and owns the PC.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int Ops  = 4,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   Instr,
  input  logic            Branch,
  output logic [PCW-1:0]  ProgCtr,
  output logic [Ops-1:0]  AluOp,
  output logic            RegWrEn,
  output logic            MemRdEn,
  output logic            MemWrEn,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt
);

  ctrl_state_t   state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [PCW-1:0] pc_q, pc_d, pc_inc, br_target;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]    opcode;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign opcode = ir_q[IW-1 -: 4];
  assign pc_inc = pc_q + PCW'(1);

  ctrl_sequencer_branch_lut #(.PCW(PCW)) u_branch_lut (
    .idx    (ir_q[LUT_IDXW-1:0]),
    .target (br_target)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    AluOp   = '0;
    RegWrEn = 1'b0;
    MemRdEn = 1'b0;
    MemWrEn = 1'b0;
    Done    = 1'b0;

    // the counter runs in every active state and stops in IDLE/HALT
    if (state_q != IDLE && state_q != HALT) cnt_d = sat_inc(cnt_q);

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        ir_d    = Instr;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          state_d = MEM;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else if (is_nop(opcode)) begin
          state_d = FETCH;
          pc_d    = pc_inc;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        AluOp = Ops'(opcode);
        if (opcode == OP_BNZ) begin
          state_d = FETCH;
          pc_d    = Branch ? br_target : pc_inc;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (opcode == OP_LD) begin
          MemRdEn = 1'b1;
          state_d = WB;
        end else begin
          MemWrEn = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      WB: begin
        RegWrEn = 1'b1;
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      HALT: begin
        Done = 1'b1;
        if (Start) begin
          state_d = FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr  = pc_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed programs push expected output
// events; a negedge monitor pops and compares whenever the outputs change.
module tb_ctrl_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Branch;
  logic [8:0]  Instr;
  logic [9:0]  ProgCtr;
  logic [3:0]  AluOp;
  logic        RegWrEn, MemRdEn, MemWrEn, Done;
  logic [15:0] CycleCnt;

  logic [8:0] rom  [0:1023];
  logic       brom [0:1023];

  localparam logic [8:0] I_ADD   = 9'h000;
  localparam logic [8:0] I_BNZ3  = 9'h123;
  localparam logic [8:0] I_BNZ31 = 9'h13F;
  localparam logic [8:0] I_LD    = 9'h140;
  localparam logic [8:0] I_ST    = 9'h160;
  localparam logic [8:0] I_NOP   = 9'h180;
  localparam logic [8:0] I_HALT  = 9'h1E0;

  assign Instr  = rom[ProgCtr];
  assign Branch = brom[ProgCtr];

  always #5 Clk = ~Clk;

  ctrl_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Instr    (Instr),
    .Branch   (Branch),
    .ProgCtr  (ProgCtr),
    .AluOp    (AluOp),
    .RegWrEn  (RegWrEn),
    .MemRdEn  (MemRdEn),
    .MemWrEn  (MemWrEn),
    .Done     (Done),
    .CycleCnt (CycleCnt)
  );

  typedef struct packed {
    logic        rw;
    logic        rd;
    logic        wr;
    logic        dn;
    logic [3:0]  op;
    logic [9:0]  pc;
    logic [15:0] cnt;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    tmo_cnt = 0;
  int    tmo_seen = 0;
  logic  mon_en = 1'b0;
  logic  snap = 1'b0;

  ev_t         e_mon, a_mon;
  string       n_mon;
  logic [17:0] cur_t, prev_t;

  // monitor: an event is any change of the visible outputs, or a snapshot request
  always @(negedge Clk) begin
    cur_t = {RegWrEn, MemRdEn, MemWrEn, Done, AluOp, ProgCtr};
    if (tmo_cnt != tmo_seen) begin
      compared++;
      mismatched++;
      tmo_seen++;
    end
    if (mon_en && (cur_t != prev_t || snap)) begin
      a_mon = {RegWrEn, MemRdEn, MemWrEn, Done, AluOp, ProgCtr, CycleCnt};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got rw=%0b rd=%0b wr=%0b done=%0b op=%h pc=%0d cnt=%0d, none expected",
                 a_mon.rw, a_mon.rd, a_mon.wr, a_mon.dn, a_mon.op, a_mon.pc, a_mon.cnt);
      end else begin
        e_mon = exp_q.pop_front();
        n_mon = name_q.pop_front();
        if (a_mon !== e_mon) begin
          mismatched++;
          $display("FAIL %s: got rw=%0b rd=%0b wr=%0b done=%0b op=%h pc=%0d cnt=%0d, want rw=%0b rd=%0b wr=%0b done=%0b op=%h pc=%0d cnt=%0d",
                   n_mon, a_mon.rw, a_mon.rd, a_mon.wr, a_mon.dn, a_mon.op, a_mon.pc, a_mon.cnt,
                   e_mon.rw, e_mon.rd, e_mon.wr, e_mon.dn, e_mon.op, e_mon.pc, e_mon.cnt);
        end
      end
    end
    prev_t = cur_t;
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic expect_ev(input string nm, input logic rw, input logic rd, input logic wr,
                           input logic dn, input logic [3:0] op, input logic [9:0] pc,
                           input logic [15:0] cnt);
    ev_t e;
    e = {rw, rd, wr, dn, op, pc, cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic snapshot(input string nm, input logic dn, input logic [9:0] pc,
                          input logic [15:0] cnt);
    expect_ev(nm, 1'b0, 1'b0, 1'b0, dn, 4'h0, pc, cnt);
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = I_HALT;
      brom[i] = 1'b0;
    end
  endtask

  task automatic reset_dut(input string nm);
    mon_en = 1'b0;
    Reset  = 1'b1;
    tick();
    Reset  = 1'b0;
    tick();
    mon_en = 1'b1;
    snapshot(nm, 1'b0, 10'd0, 16'd0);
  endtask

  task automatic pulse_start();
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL %s_timeout: %0d events still pending, required 0", nm, exp_q.size());
      tmo_cnt++;
      tick();
    end
  endtask

  task automatic push_nop_run();
    for (int p = 1; p <= 5; p++)
      expect_ev("nop_pc", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'(p), 16'(2 * p));
    expect_ev("nop_halt", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'd5, 16'd12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    tick();

    // ADD: FETCH, DECODE, EXEC, WB then HALT
    rom[0] = I_ADD;
    reset_dut("reset_state");
    expect_ev("add_wb",   1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 16'd3);
    expect_ev("add_pc",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1, 16'd4);
    expect_ev("add_halt", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'd1, 16'd6);
    pulse_start();
    drain("add", 30);
    repeat (4) tick();
    snapshot("add_frozen", 1'b1, 10'd1, 16'd6);

    // BNZ taken to lut[3]=40, then not taken
    clear_rom();
    rom[0] = I_BNZ3;  brom[0] = 1'b1;
    rom[40] = I_BNZ3; brom[40] = 1'b0;
    reset_dut("reset_bnz");
    expect_ev("bnz1_exec",  1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 10'd0,  16'd2);
    expect_ev("bnz1_taken", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd40, 16'd3);
    expect_ev("bnz2_exec",  1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 10'd40, 16'd5);
    expect_ev("bnz2_fall",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd41, 16'd6);
    expect_ev("bnz_halt",   1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'd41, 16'd8);
    pulse_start();
    drain("bnz", 30);

    // ST then LD
    clear_rom();
    rom[0] = I_ST;
    rom[1] = I_LD;
    reset_dut("reset_mem");
    expect_ev("st_wr",   1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd0, 16'd2);
    expect_ev("st_pc",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1, 16'd3);
    expect_ev("ld_rd",   1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd1, 16'd5);
    expect_ev("ld_wb",   1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1, 16'd6);
    expect_ev("ld_pc",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd2, 16'd7);
    expect_ev("mem_halt",1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'd2, 16'd9);
    pulse_start();
    drain("mem", 30);

    // NOPs to HALT at PC=5, counter frozen, restart from HALT
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = I_NOP;
    reset_dut("reset_halt");
    push_nop_run();
    pulse_start();
    drain("halt1", 40);
    repeat (5) tick();
    snapshot("halt_frozen", 1'b1, 10'd5, 16'd12);
    expect_ev("restart", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 16'd0);
    push_nop_run();
    pulse_start();
    drain("halt2", 40);

    // reset while ST is in MEM
    clear_rom();
    rom[0] = I_NOP;
    rom[1] = I_ST;
    reset_dut("reset_pre_abort");
    expect_ev("abort_pc1", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1, 16'd2);
    expect_ev("abort_wr",  1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd1, 16'd4);
    expect_ev("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 16'd0);
    pulse_start();
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (10) tick();
    snapshot("abort_idle", 1'b0, 10'd0, 16'd0);
    drain("abort", 5);

    // branch to 1023, ADD wraps PC to 0; Start mid-run ignored
    clear_rom();
    rom[0] = I_BNZ31; brom[0] = 1'b1;
    rom[1023] = I_ADD;
    reset_dut("reset_wrap");
    expect_ev("wrap_exec", 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 10'd0,    16'd2);
    expect_ev("wrap_br",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1023, 16'd3);
    expect_ev("wrap_wb",   1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd1023, 16'd6);
    expect_ev("wrap_pc0",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0,    16'd7);
    expect_ev("wrap_halt", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'd0,    16'd9);
    pulse_start();
    tick();
    rom[0] = I_HALT;
    tick();
    tick();
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    drain("wrap", 30);
    repeat (3) tick();
    snapshot("wrap_frozen", 1'b1, 10'd0, 16'd9);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
